// File: rtl/reaction_auto_responder.sv
// Scripted stand-in for the human user of reaction_time_benchmark: starts a trial,
// presses after a programmed delay and checks the multiplexed digits it reads back.
module reaction_auto_responder #(
  parameter int CLKS_PER_MS      = 50,
  parameter int START_PULSE_CLKS = 10,
  parameter int PRESS_MS         = 10,
  parameter int REACT_TIMEOUT_MS = 8000,
  parameter int CAPTURE_MS       = 20,
  parameter int TOL_MS           = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go,
  input  logic [13:0] response_ms,
  input  logic        react,
  input  logic [3:0]  ms,
  input  logic [1:0]  display_select,
  output logic        start_trigger,
  output logic        user_trigger,
  output logic        busy,
  output logic        done,
  output logic [15:0] measured_bcd,
  output logic        match,
  output logic        timeout
);

  localparam int TW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int SW = (START_PULSE_CLKS > 1) ? $clog2(START_PULSE_CLKS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_REACT, S_DELAY, S_PRESS, S_CAPTURE, S_DONE
  } state_t;

  state_t      state;
  logic [TW-1:0] tick_cnt;
  logic [13:0] ms_cnt;
  logic [SW-1:0] start_cnt;
  logic [13:0] resp_lat;
  logic [3:0]  digit_seen;
  logic        react_q;
  logic [1:0]  sel_q;

  logic        ms_tick;
  logic        react_edge;
  logic        sel_stable;
  logic [15:0] bin_val;
  logic [15:0] diff;
  logic        digits_ok;
  logic        match_calc;

  assign ms_tick    = (tick_cnt == TW'(CLKS_PER_MS - 1));
  assign react_edge = react & ~react_q;
  assign sel_stable = (display_select == sel_q);

  // BCD -> binary; 16 bits so out-of-range nibbles cannot wrap into a false match
  assign bin_val = ({12'd0, measured_bcd[15:12]} * 16'd1000)
                 + ({12'd0, measured_bcd[11:8]}  * 16'd100)
                 + ({12'd0, measured_bcd[7:4]}   * 16'd10)
                 +  {12'd0, measured_bcd[3:0]};

  assign digits_ok = (measured_bcd[15:12] <= 4'd9) && (measured_bcd[11:8] <= 4'd9) &&
                     (measured_bcd[7:4]   <= 4'd9) && (measured_bcd[3:0]  <= 4'd9);

  assign diff = (bin_val >= {2'b00, resp_lat}) ? (bin_val - {2'b00, resp_lat})
                                               : ({2'b00, resp_lat} - bin_val);

  assign match_calc = digits_ok && (digit_seen == 4'hF) && (diff <= 16'(TOL_MS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      tick_cnt      <= '0;
      ms_cnt        <= '0;
      start_cnt     <= '0;
      resp_lat      <= '0;
      digit_seen    <= '0;
      react_q       <= 1'b0;
      sel_q         <= '0;
      start_trigger <= 1'b0;
      user_trigger  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      measured_bcd  <= '0;
      match         <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      react_q  <= react;
      sel_q    <= display_select;
      done     <= 1'b0;
      tick_cnt <= ms_tick ? '0 : tick_cnt + TW'(1);
      if (ms_tick) ms_cnt <= ms_cnt + 14'd1;

      // Every state change below also zeroes the timebase so ms windows are exact.
      case (state)
        S_IDLE: begin
          if (go) begin
            resp_lat      <= response_ms;
            measured_bcd  <= '0;
            match         <= 1'b0;
            timeout       <= 1'b0;
            digit_seen    <= '0;
            busy          <= 1'b1;
            start_trigger <= 1'b1;
            start_cnt     <= '0;
            tick_cnt      <= '0;
            ms_cnt        <= '0;
            state         <= S_START;
          end
        end

        S_START: begin
          if (start_cnt == SW'(START_PULSE_CLKS - 1)) begin
            start_trigger <= 1'b0;
            tick_cnt      <= '0;
            ms_cnt        <= '0;
            state         <= S_WAIT_REACT;
          end else begin
            start_cnt <= start_cnt + SW'(1);
          end
        end

        S_WAIT_REACT: begin
          if (react_edge) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
            state    <= S_DELAY;
          end else if (ms_tick && ms_cnt == 14'(REACT_TIMEOUT_MS - 1)) begin
            timeout  <= 1'b1;
            match    <= 1'b0;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            state    <= S_DONE;
          end
        end

        S_DELAY: begin
          if (resp_lat == 14'd0 || (ms_tick && ms_cnt == resp_lat - 14'd1)) begin
            user_trigger <= 1'b1;
            tick_cnt     <= '0;
            ms_cnt       <= '0;
            state        <= S_PRESS;
          end
        end

        S_PRESS: begin
          if (ms_tick && ms_cnt == 14'(PRESS_MS - 1)) begin
            user_trigger <= 1'b0;
            tick_cnt     <= '0;
            ms_cnt       <= '0;
            state        <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          if (digit_seen == 4'hF || (ms_tick && ms_cnt == 14'(CAPTURE_MS - 1))) begin
            tick_cnt <= '0;
            ms_cnt   <= '0;
            state    <= S_DONE;
          end else if (sel_stable) begin
            // a select held two cycles means the digit on ms has settled
            measured_bcd[{display_select, 2'b00} +: 4] <= ms;
            digit_seen[display_select]                 <= 1'b1;
          end
        end

        S_DONE: begin
          done     <= 1'b1;
          busy     <= 1'b0;
          if (!timeout) match <= match_calc;
          tick_cnt <= '0;
          ms_cnt   <= '0;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_auto_responder.sv
// Directed bench: plays the benchmark side (react + digit mux) with hand-computed expectations.
module tb_reaction_auto_responder;

  localparam int CPM   = 4;
  localparam int START = 10;
  localparam int PRESS = 10;
  localparam int RTO   = 200;
  localparam int CAP   = 20;
  localparam int TOL   = 1;

  logic        clk;
  logic        rst;
  logic        go;
  logic [13:0] response_ms;
  logic        react;
  logic [3:0]  ms;
  logic [1:0]  display_select;
  logic        start_trigger, user_trigger, busy, done, match, timeout;
  logic [15:0] measured_bcd;

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int ut_cnt   = 0;
  int overlap  = 0;

  logic [15:0] disp_val = 16'h0000;
  int          dmode    = 0;
  logic [2:0]  phase    = 3'd0;

  reaction_auto_responder #(
    .CLKS_PER_MS(CPM), .START_PULSE_CLKS(START), .PRESS_MS(PRESS),
    .REACT_TIMEOUT_MS(RTO), .CAPTURE_MS(CAP), .TOL_MS(TOL)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .response_ms(response_ms), .react(react),
    .ms(ms), .display_select(display_select), .start_trigger(start_trigger),
    .user_trigger(user_trigger), .busy(busy), .done(done),
    .measured_bcd(measured_bcd), .match(match), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Benchmark digit mux: 0 = rotate every 2 cycles, 1 = stuck at ones, 2 = change every cycle
  always @(negedge clk) begin
    phase = phase + 3'd1;
    case (dmode)
      0:       display_select = phase[2:1];
      1:       display_select = 2'd0;
      default: display_select = phase[1:0];
    endcase
    ms = disp_val[{display_select, 2'b00} +: 4];
    if (done) done_cnt++;
    if (user_trigger) ut_cnt++;
    if (start_trigger && user_trigger) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_trial(input string tag, input logic [13:0] resp, input int react_ms,
                           input logic [15:0] disp, input int dm, input int exp_rise,
                           input logic exp_match, input logic [15:0] exp_bcd);
    int n;
    dmode = dm;
    disp_val = disp;
    go = 1'b1;
    response_ms = resp;
    tick();
    go = 1'b0;
    response_ms = 14'd9999;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_clr"}, {15'd0, match, measured_bcd}, 32'd0);
    n = 0;
    while (start_trigger && n < 100) begin tick(); n++; end
    chk({tag, "_start_len"}, n, START);
    // go while busy must not relatch response_ms
    go = 1'b1;
    tick();
    go = 1'b0;
    if (react) begin react = 1'b0; tick(); end
    repeat (react_ms * CPM) tick();
    react = 1'b1;
    n = 0;
    while (!user_trigger && n < 20000) begin tick(); n++; end
    chk({tag, "_rise"}, n, exp_rise);
    n = 0;
    while (user_trigger && n < 1000) begin tick(); n++; end
    chk({tag, "_press_len"}, n, PRESS * CPM);
    react = 1'b0;
    n = 0;
    while (!done && n < 500) begin tick(); n++; end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_res"}, {busy, timeout, match, measured_bcd}, {1'b0, 1'b0, exp_match, exp_bcd});
    tick();
    chk({tag, "_done_w"}, {done, match}, {1'b0, exp_match});
  endtask

  initial begin
    int n;
    int d0;
    int u0;
    rst = 1'b1; go = 1'b0; response_ms = '0; react = 1'b0;
    repeat (2) tick();
    chk("reset_outs", {start_trigger, user_trigger, busy, done, match, timeout, measured_bcd}, 32'd0);
    rst = 1'b0;
    tick();

    // reset while user_trigger is high
    go = 1'b1; response_ms = 14'd5; tick(); go = 1'b0;
    repeat (START + CPM) tick();
    react = 1'b1;
    n = 0;
    while (!user_trigger && n < 200) begin tick(); n++; end
    chk("mid_ut_high", 32'(user_trigger), 32'd1);
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    chk("mid_rst_outs", {start_trigger, user_trigger, busy, done, match, timeout, measured_bcd}, 32'd0);
    tick();
    rst = 1'b0; react = 1'b0;
    repeat (3) tick();
    chk("mid_rst_idle", {start_trigger, user_trigger, busy, done, match, timeout, measured_bcd}, 32'd0);
    chk("mid_rst_nodone", done_cnt - d0, 0);

    run_trial("nominal", 14'd1230, 40, 16'h1230, 0, 1230 * CPM + 1, 1'b1, 16'h1230);
    run_trial("tol_p1",  14'd1450, 2,  16'h1451, 0, 1450 * CPM + 1, 1'b1, 16'h1451);
    run_trial("tol_p2",  14'd1450, 2,  16'h1452, 0, 1450 * CPM + 1, 1'b0, 16'h1452);
    run_trial("nib_a",   14'd1450, 2,  16'h144A, 0, 1450 * CPM + 1, 1'b0, 16'h144A);
    run_trial("stuck",   14'd7,    2,  16'h0007, 1, 7 * CPM + 1,    1'b0, 16'h0007);
    run_trial("cycling", 14'd7,    2,  16'h0007, 2, 7 * CPM + 1,    1'b0, 16'h0000);
    react = 1'b1;
    run_trial("pre_react", 14'd3,  2,  16'h0003, 0, 3 * CPM + 1,    1'b1, 16'h0003);
    run_trial("zero",    14'd0,    2,  16'h0000, 0, 2,              1'b1, 16'h0000);

    // react never rises
    react = 1'b0;
    u0 = ut_cnt;
    go = 1'b1; response_ms = 14'd100; tick(); go = 1'b0;
    n = 0;
    while (!done && n < 2000) begin tick(); n++; end
    chk("to_latency", n, START + RTO * CPM + 1);
    chk("to_res", {busy, timeout, match, measured_bcd}, {1'b0, 1'b1, 1'b0, 16'h0000});
    chk("to_no_press", ut_cnt - u0, 0);
    chk("no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
